// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Sequential load/store unit for the MEM stage. It accepts one decoded
//   load or store at a time and drives a single-outstanding valid/ready data
//   bus with bus-aligned addresses, byte strobes and lane-shifted write data.
//   Load data is extracted from one or two captured beats and then sign- or
//   zero-extended. Exactly one response is returned per request. An access
//   that crosses a bus word is either split into two beats or, when
//   ALLOW_MISALIGN=0, any naturally misaligned access is rejected with
//   resp_err and generates no bus traffic.
//
// Ports
//   clk, rst                   rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (ready only when idle)
//   load_info[6:0]             one-hot lb,lh,lw,ld,lbu,lhu,lwu (bit 0..6)
//   save_info[3:0]             one-hot sb,sh,sw,sd (bit 0..3)
//   req_addr, req_wdata        byte address, right-aligned store data
//   resp_valid/resp_ready      response handshake; data held until consumed
//   resp_data, resp_err        extended load result / misalignment error
//   bus_valid/bus_ready        bus request handshake
//   bus_addr, bus_we           aligned beat address, write enable
//   bus_wstrb, bus_wdata       byte enables and lane-shifted store data
//   bus_rvalid, bus_rdata      beat completion and read data
module mem_access_unit #(
  parameter int XLEN           = 64,
  parameter int BUS_BYTES      = 8,
  parameter int ALLOW_MISALIGN = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [6:0]             load_info,
  input  logic [3:0]             save_info,
  input  logic [XLEN-1:0]        req_addr,
  input  logic [XLEN-1:0]        req_wdata,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [XLEN-1:0]        resp_data,
  output logic                   resp_err,
  output logic                   bus_valid,
  input  logic                   bus_ready,
  output logic [XLEN-1:0]        bus_addr,
  output logic                   bus_we,
  output logic [BUS_BYTES-1:0]   bus_wstrb,
  output logic [8*BUS_BYTES-1:0] bus_wdata,
  input  logic                   bus_rvalid,
  input  logic [8*BUS_BYTES-1:0] bus_rdata
);

  localparam int BW   = 8 * BUS_BYTES;   // bus data width
  localparam int DW   = 2 * BW;          // two-beat data window
  localparam int MW   = 2 * BUS_BYTES;   // two-beat strobe window
  localparam int OFFW = $clog2(BUS_BYTES);
  localparam int SW   = OFFW + 2;        // holds off+size without overflow
  localparam int NB   = XLEN / 8;

  localparam int LD_LB = 0, LD_LH = 1, LD_LW = 2, LD_LBU = 4, LD_LHU = 5, LD_LWU = 6;
  localparam int ST_SB = 0, ST_SH = 1, ST_SW = 2;

  typedef enum logic [2:0] {IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP} state_t;

  state_t state_reg, state_next;

  logic            op_load_reg, op_store_reg, sign_reg, split_reg, err_reg;
  logic [3:0]      size_reg;
  logic [XLEN-1:0] addr_reg, wdata_reg;
  logic [BW-1:0]   beat0_reg, beat1_reg;

  // Request decode (load wins if both one-hots are set)
  logic            is_load, is_store, is_access, req_sign, req_split, misalign_err;
  logic [3:0]      req_size;

  always_comb begin
    is_load   = |load_info;
    is_store  = !is_load && (|save_info);
    is_access = is_load || is_store;
    req_size  = 4'd0;
    req_sign  = 1'b0;
    if (is_load) begin
      req_sign = load_info[LD_LB] | load_info[LD_LH] | load_info[LD_LW];
      if (load_info[LD_LB] | load_info[LD_LBU])      req_size = 4'd1;
      else if (load_info[LD_LH] | load_info[LD_LHU]) req_size = 4'd2;
      else if (load_info[LD_LW] | load_info[LD_LWU]) req_size = 4'd4;
      else                                           req_size = 4'd8;
    end else if (is_store) begin
      if (save_info[ST_SB])      req_size = 4'd1;
      else if (save_info[ST_SH]) req_size = 4'd2;
      else if (save_info[ST_SW]) req_size = 4'd4;
      else                       req_size = 4'd8;
    end
    req_split    = (SW'(req_addr[OFFW-1:0]) + SW'(req_size)) > SW'(BUS_BYTES);
    // size is a power of two, so addr mod size is addr & (size-1)
    misalign_err = (ALLOW_MISALIGN == 0) && is_access &&
                   ((req_addr[2:0] & 3'(req_size - 4'd1)) != 3'd0);
  end

  // Beat shaping from the registered request
  logic [OFFW-1:0] off;
  logic [XLEN-1:0] aligned_addr;
  logic [MW-1:0]   size_mask, mask_wide;
  logic [DW-1:0]   data_wide;

  assign off          = addr_reg[OFFW-1:0];
  assign aligned_addr = {addr_reg[XLEN-1:OFFW], {OFFW{1'b0}}};
  // For MW=8 the 1<<8 wraps to 0 and the subtraction still yields 0xFF.
  assign size_mask    = (MW'(1) << size_reg) - MW'(1);
  assign mask_wide    = size_mask << off;
  assign data_wide    = DW'(wdata_reg) << {off, 3'b000};

  // Load extraction: shift the two-beat window down, then extend per byte lane
  logic [XLEN-1:0] load_raw, load_val;
  logic            msb, sign_bit;

  assign load_raw = XLEN'({beat1_reg, beat0_reg} >> {off, 3'b000});

  always_comb begin
    case (size_reg)
      4'd1:    msb = load_raw[7];
      4'd2:    msb = load_raw[15];
      4'd4:    msb = load_raw[31];
      default: msb = load_raw[XLEN-1];
    endcase
    sign_bit = sign_reg & msb;
  end

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign load_val[8*gi +: 8] = (4'(gi) < size_reg) ? load_raw[8*gi +: 8] : {8{sign_bit}};
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Next state and outputs
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_data  = '0;
    bus_valid  = 1'b0;
    bus_addr   = '0;
    bus_we     = 1'b0;
    bus_wstrb  = '0;
    bus_wdata  = '0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = (!is_access || misalign_err) ? RESP : ISSUE0;
      end
      ISSUE0: begin
        bus_valid = 1'b1;
        bus_addr  = aligned_addr;
        bus_we    = op_store_reg;
        bus_wstrb = mask_wide[BUS_BYTES-1:0];
        bus_wdata = data_wide[BW-1:0];
        if (bus_ready) state_next = WAIT0;
      end
      WAIT0: if (bus_rvalid) state_next = split_reg ? ISSUE1 : RESP;
      ISSUE1: begin
        bus_valid = 1'b1;
        bus_addr  = aligned_addr + XLEN'(BUS_BYTES);
        bus_we    = op_store_reg;
        bus_wstrb = mask_wide[MW-1:BUS_BYTES];
        bus_wdata = data_wide[DW-1:BW];
        if (bus_ready) state_next = WAIT1;
      end
      WAIT1: if (bus_rvalid) state_next = RESP;
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_reg;
        if (op_load_reg && !err_reg) resp_data = load_val;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture and beat buffer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_load_reg  <= 1'b0;
      op_store_reg <= 1'b0;
      sign_reg     <= 1'b0;
      split_reg    <= 1'b0;
      err_reg      <= 1'b0;
      size_reg     <= '0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      beat0_reg    <= '0;
      beat1_reg    <= '0;
    end else begin
      if (state_reg == IDLE && req_valid) begin
        op_load_reg  <= is_load;
        op_store_reg <= is_store;
        sign_reg     <= req_sign;
        split_reg    <= req_split;
        err_reg      <= misalign_err;
        size_reg     <= req_size;
        addr_reg     <= req_addr;
        wdata_reg    <= req_wdata;
      end
      if (state_reg == WAIT0 && bus_rvalid) beat0_reg <= bus_rdata;
      if (state_reg == WAIT1 && bus_rvalid) beat1_reg <= bus_rdata;
    end
  end

  // A request must not be both a load and a store
  a_one_op: assert property (@(posedge clk) disable iff (!rst)
    (req_valid && req_ready) |-> !((|load_info) && (|save_info)));

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  // main instance (split misaligned accesses)
  logic        req_valid, req_ready, resp_valid, resp_ready, resp_err;
  logic [6:0]  load_info;
  logic [3:0]  save_info;
  logic [63:0] req_addr, req_wdata, resp_data;
  logic        bus_valid, bus_ready, bus_we, bus_rvalid;
  logic [63:0] bus_addr, bus_wdata, bus_rdata;
  logic [7:0]  bus_wstrb;
  // error-mode instance (ALLOW_MISALIGN=0)
  logic        e_req_valid, e_req_ready, e_resp_valid, e_resp_ready, e_resp_err;
  logic [6:0]  e_load_info;
  logic [3:0]  e_save_info;
  logic [63:0] e_req_addr, e_req_wdata, e_resp_data;
  logic        e_bus_valid, e_bus_ready, e_bus_we, e_bus_rvalid;
  logic [63:0] e_bus_addr, e_bus_wdata, e_bus_rdata;
  logic [7:0]  e_bus_wstrb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .load_info(load_info), .save_info(save_info), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr), .bus_we(bus_we),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  mem_access_unit #(.ALLOW_MISALIGN(0)) dut_e (
    .clk(clk), .rst(rst), .req_valid(e_req_valid), .req_ready(e_req_ready),
    .load_info(e_load_info), .save_info(e_save_info), .req_addr(e_req_addr), .req_wdata(e_req_wdata),
    .resp_valid(e_resp_valid), .resp_ready(e_resp_ready), .resp_data(e_resp_data), .resp_err(e_resp_err),
    .bus_valid(e_bus_valid), .bus_ready(e_bus_ready), .bus_addr(e_bus_addr), .bus_we(e_bus_we),
    .bus_wstrb(e_bus_wstrb), .bus_wdata(e_bus_wdata), .bus_rvalid(e_bus_rvalid), .bus_rdata(e_bus_rdata)
  );

  typedef struct {
    logic [6:0]  li;
    logic [3:0]  si;
    logic [63:0] addr, wdata, rd0, rd1;
    int          beats;
    logic [63:0] a0;
    logic [7:0]  s0;
    logic [63:0] w0, a1;
    logic [7:0]  s1;
    logic [63:0] w1;
    logic        we;
    logic [63:0] resp;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Drive one request on the main instance with a zero-wait bus, check every beat and the response.
  task automatic run_vec(input vec_t v, input int idx);
    int cnt;
    bit seen;
    @(negedge clk);
    chk("req_ready idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; load_info = v.li; save_info = v.si; req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; load_info = '0; save_info = '0;
    cnt = 1;
    if (v.beats == 0) chk("no bus beat", 64'(bus_valid), 64'd0);
    for (int b = 0; b < v.beats; b++) begin
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
        if (bus_valid) seen = 1'b1;
        else begin @(posedge clk); #1; cnt++; end
      end
      chk("bus_valid seen", 64'(seen), 64'd1);
      if (!seen) return;
      chk("bus_addr",  bus_addr, (b == 0) ? v.a0 : v.a1);
      chk("bus_wstrb", 64'(bus_wstrb), 64'((b == 0) ? v.s0 : v.s1));
      chk("bus_wdata", bus_wdata, (b == 0) ? v.w0 : v.w1);
      chk("bus_we",    64'(bus_we), 64'(v.we));
      bus_ready = 1'b1;
      @(posedge clk); #1; cnt++;
      bus_ready = 1'b0;
      bus_rvalid = 1'b1; bus_rdata = (b == 0) ? v.rd0 : v.rd1;
      @(posedge clk); #1; cnt++;
      bus_rvalid = 1'b0; bus_rdata = '0;
    end
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      if (resp_valid) seen = 1'b1;
      else begin @(posedge clk); #1; cnt++; end
    end
    chk("resp_valid seen", 64'(seen), 64'd1);
    chk("latency", 64'(cnt), 64'((v.beats == 0) ? 1 : 1 + 2 * v.beats));
    chk("resp_data", resp_data, v.resp);
    chk("resp_err",  64'(resp_err), 64'd0);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("resp_valid drop", 64'(resp_valid), 64'd0);
    chk("req_ready back",  64'(req_ready), 64'd1);
    $display("txn %0d: addr=0x%h beats=%0d resp_data=0x%h latency=%0d", idx, v.addr, v.beats, resp_data, cnt);
  endtask

  initial begin
    // li, si, addr, wdata, rd0, rd1, beats, a0, s0, w0, a1, s1, w1, we, resp
    vecs[0]  = '{7'h01, 4'h0, 64'h1007, 64'h0, 64'h8000_0000_0000_0000, 64'h0, 1,
                 64'h1000, 8'h80, 64'h0, 64'h0, 8'h00, 64'h0, 1'b0, 64'hFFFF_FFFF_FFFF_FF80};
    vecs[1]  = '{7'h00, 4'h4, 64'h1004, 64'hDEAD_BEEF_1234_5678, 64'h5A5A_5A5A_5A5A_5A5A, 64'h0, 1,
                 64'h1000, 8'hF0, 64'h1234_5678_0000_0000, 64'h0, 8'h00, 64'h0, 1'b1, 64'h0};
    vecs[2]  = '{7'h08, 4'h0, 64'h1006, 64'h0, 64'hBBAA_1111_2222_3333, 64'h9999_5566_7788_99CC, 2,
                 64'h1000, 8'hC0, 64'h0, 64'h1008, 8'h3F, 64'h0, 1'b0, 64'h5566_7788_99CC_BBAA};
    vecs[3]  = '{7'h10, 4'h0, 64'h1003, 64'h0, 64'h1122_3344_F566_7788, 64'h0, 1,
                 64'h1000, 8'h08, 64'h0, 64'h0, 8'h00, 64'h0, 1'b0, 64'h0000_0000_0000_00F5};
    vecs[4]  = '{7'h02, 4'h0, 64'h2002, 64'h0, 64'h0000_0000_8001_0000, 64'h0, 1,
                 64'h2000, 8'h0C, 64'h0, 64'h0, 8'h00, 64'h0, 1'b0, 64'hFFFF_FFFF_FFFF_8001};
    vecs[5]  = '{7'h04, 4'h0, 64'h3000, 64'h0, 64'hAAAA_AAAA_7654_3210, 64'h0, 1,
                 64'h3000, 8'h0F, 64'h0, 64'h0, 8'h00, 64'h0, 1'b0, 64'h0000_0000_7654_3210};
    vecs[6]  = '{7'h40, 4'h0, 64'h3004, 64'h0, 64'h8765_4321_0000_0000, 64'h0, 1,
                 64'h3000, 8'hF0, 64'h0, 64'h0, 8'h00, 64'h0, 1'b0, 64'h0000_0000_8765_4321};
    vecs[7]  = '{7'h00, 4'h2, 64'h1007, 64'hABCD, 64'h0, 64'h0, 2,
                 64'h1000, 8'h80, 64'hCD00_0000_0000_0000, 64'h1008, 8'h01, 64'h0000_0000_0000_00AB, 1'b1, 64'h0};
    vecs[8]  = '{7'h00, 4'h8, 64'h4000, 64'h0123_4567_89AB_CDEF, 64'h0, 64'h0, 1,
                 64'h4000, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0, 8'h00, 64'h0, 1'b1, 64'h0};
    vecs[9]  = '{7'h00, 4'h1, 64'h4005, 64'h7E, 64'h0, 64'h0, 1,
                 64'h4000, 8'h20, 64'h0000_7E00_0000_0000, 64'h0, 8'h00, 64'h0, 1'b1, 64'h0};
    vecs[10] = '{7'h00, 4'h0, 64'h5000, 64'h0, 64'h0, 64'h0, 0,
                 64'h0, 8'h00, 64'h0, 64'h0, 8'h00, 64'h0, 1'b0, 64'h0};
    vecs[11] = '{7'h04, 4'h0, 64'h1006, 64'h0, 64'h8899_0000_0000_0000, 64'h0000_0000_0000_F011, 2,
                 64'h1000, 8'hC0, 64'h0, 64'h1008, 8'h03, 64'h0, 1'b0, 64'hFFFF_FFFF_F011_8899};
    vecs[12] = '{7'h20, 4'h0, 64'h1006, 64'h0, 64'hFEDC_0000_0000_0000, 64'h0, 1,
                 64'h1000, 8'hC0, 64'h0, 64'h0, 8'h00, 64'h0, 1'b0, 64'h0000_0000_0000_FEDC};

    rst = 1'b0;
    req_valid = 0; load_info = '0; save_info = '0; req_addr = '0; req_wdata = '0;
    resp_ready = 0; bus_ready = 0; bus_rvalid = 0; bus_rdata = '0;
    e_req_valid = 0; e_load_info = '0; e_save_info = '0; e_req_addr = '0; e_req_wdata = '0;
    e_resp_ready = 0; e_bus_ready = 0; e_bus_rvalid = 0; e_bus_rdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst req_ready",  64'(req_ready), 64'd1);
    chk("rst resp_valid", 64'(resp_valid), 64'd0);
    chk("rst bus_valid",  64'(bus_valid), 64'd0);
    chk("rst resp_data",  resp_data, 64'd0);
    chk("rst bus_wstrb",  64'(bus_wstrb), 64'd0);
    chk("rst e_req_ready", 64'(e_req_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // Misaligned accesses rejected by the ALLOW_MISALIGN=0 instance
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      e_req_valid = 1'b1;
      e_load_info = (k == 0) ? 7'h02 : 7'h04;
      e_req_addr  = (k == 0) ? 64'h1001 : 64'h1002;
      @(posedge clk); #1;
      e_req_valid = 1'b0; e_load_info = '0;
      chk("err resp_valid", 64'(e_resp_valid), 64'd1);
      chk("err resp_err",   64'(e_resp_err), 64'd1);
      chk("err resp_data",  e_resp_data, 64'd0);
      chk("err no bus",     64'(e_bus_valid), 64'd0);
      e_resp_ready = 1'b1;
      @(posedge clk); #1;
      e_resp_ready = 1'b0;
      chk("err req_ready", 64'(e_req_ready), 64'd1);
      $display("err txn %0d: addr=0x%h resp_err=%0d", k, e_req_addr, e_resp_err);
    end

    // Aligned access on the ALLOW_MISALIGN=0 instance goes to the bus normally
    @(negedge clk);
    e_req_valid = 1'b1; e_load_info = 7'h02; e_req_addr = 64'h1002; e_bus_ready = 1'b1;
    @(posedge clk); #1;
    e_req_valid = 1'b0; e_load_info = '0;
    chk("e bus_valid", 64'(e_bus_valid), 64'd1);
    chk("e bus_addr",  e_bus_addr, 64'h1000);
    chk("e bus_wstrb", 64'(e_bus_wstrb), 64'h0C);
    @(posedge clk); #1;
    e_bus_ready = 1'b0; e_bus_rvalid = 1'b1; e_bus_rdata = 64'h0000_0000_7FFE_0000;
    @(posedge clk); #1;
    e_bus_rvalid = 1'b0;
    chk("e resp_valid", 64'(e_resp_valid), 64'd1);
    chk("e resp_err",   64'(e_resp_err), 64'd0);
    chk("e resp_data",  e_resp_data, 64'h7FFE);
    e_resp_ready = 1'b1;
    @(posedge clk); #1;
    e_resp_ready = 1'b0;
    $display("e txn aligned lh: resp_data=0x%h", e_resp_data);

    // Bus and response back-pressure; busy-time inputs and stray rvalid must be ignored
    @(negedge clk);
    req_valid = 1'b1; load_info = 7'h04; req_addr = 64'h1004; req_wdata = 64'hCAFE_F00D;
    @(posedge clk); #1;
    load_info = 7'h01; req_addr = 64'h7770; req_wdata = 64'h1111;
    bus_rvalid = 1'b1; bus_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      chk("stall bus_valid", 64'(bus_valid), 64'd1);
      chk("stall bus_addr",  bus_addr, 64'h1000);
      chk("stall bus_wstrb", 64'(bus_wstrb), 64'hF0);
      chk("stall bus_wdata", bus_wdata, 64'hCAFE_F00D_0000_0000);
      chk("stall req_ready", 64'(req_ready), 64'd0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0; load_info = '0;
    bus_rvalid = 1'b0; bus_ready = 1'b1;
    @(posedge clk); #1;
    bus_ready = 1'b0;
    chk("stall bus released", 64'(bus_valid), 64'd0);
    bus_rvalid = 1'b1; bus_rdata = 64'h9357_9BDF_0000_0000;
    @(posedge clk); #1;
    bus_rvalid = 1'b0; bus_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      chk("hold resp_valid", 64'(resp_valid), 64'd1);
      chk("hold resp_data",  resp_data, 64'hFFFF_FFFF_9357_9BDF);
      chk("hold req_ready",  64'(req_ready), 64'd0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("hold resp released", 64'(resp_valid), 64'd0);
    $display("stall txn: lw 0x1004 resp_data held through back-pressure");

    // Reset asserted while waiting for the second beat of a split ld
    @(negedge clk);
    req_valid = 1'b1; load_info = 7'h08; req_addr = 64'h1006; req_wdata = '0;
    @(posedge clk); #1;
    req_valid = 1'b0; load_info = '0;
    bus_ready = 1'b1;
    @(posedge clk); #1;
    bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 64'h1234_5678_9ABC_DEF0;
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    chk("rst-seq issue1 addr", bus_addr, 64'h1008);
    bus_ready = 1'b1;
    @(posedge clk); #1;
    bus_ready = 1'b0;
    rst = 1'b0;
    #1;
    chk("midrst req_ready",  64'(req_ready), 64'd1);
    chk("midrst bus_valid",  64'(bus_valid), 64'd0);
    chk("midrst bus_addr",   bus_addr, 64'd0);
    chk("midrst resp_valid", 64'(resp_valid), 64'd0);
    @(posedge clk); #1;
    chk("midrst hold resp_valid", 64'(resp_valid), 64'd0);
    chk("midrst hold wstrb",      64'(bus_wstrb), 64'd0);
    $display("reset txn: split ld aborted in WAIT1");
    @(negedge clk);
    rst = 1'b1;
    run_vec('{7'h40, 4'h0, 64'h2000, 64'h0, 64'hFFFF_FFFF_8000_0001, 64'h0, 1,
              64'h2000, 8'h0F, 64'h0, 64'h0, 8'h00, 64'h0, 1'b0, 64'h0000_0000_8000_0001}, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule
